demux_seq: RTL and testbench

DEMUX_SEQ -- requirements
Module: demux_seq

---
 rtl/demux_pkg.sv | 13 +
 rtl/dwell_timer.sv | 39 +++
 rtl/demux_seq.sv | 130 +++++++++++++
 tb/tb_demux_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux sequencer: channel count and FSM encoding.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2
  } state_e;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times the DRIVE phase: load DWELL, decrement each cycle,
// expire_o marks the final data-valid cycle.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(DWELL + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(DWELL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/demux_seq.sv
// Serialises a 4-bit word onto a 1:4 demux: per channel one break-before-make
// SETUP cycle (d=0) followed by DWELL cycles of data, outputs all registered.
module demux_seq
  import demux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int NCH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] in_word,
  output logic              in_ready,
  input  logic              abort,
  output logic              d,
  output logic              s1,
  output logic              s0,
  output logic              busy,
  output logic              done
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              d_q, d_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_dec, tmr_clear, tmr_expire;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .dec_i    (tmr_dec),
    .clear_i  (tmr_clear),
    .expire_o (tmr_expire)
  );

  // Outputs are computed from the next state so they land in registers.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    word_d    = word_q;
    sel_d     = sel_q;
    d_d       = d_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          ch_d    = '0;
          sel_d   = '0;
          d_d     = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d   = IDLE;
          ch_d      = '0;
          sel_d     = '0;
          d_d       = 1'b0;
          tmr_clear = 1'b1;
        end else begin
          state_d  = DRIVE;
          tmr_load = 1'b1;
          d_d      = word_q[ch_q];
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d   = IDLE;
          ch_d      = '0;
          sel_d     = '0;
          d_d       = 1'b0;
          tmr_clear = 1'b1;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            d_d = 1'b0;
            if (ch_q == LAST_CH) begin
              // Select stays parked on the last channel; d is already low.
              state_d = IDLE;
              ch_d    = '0;
              done_d  = 1'b1;
            end else begin
              state_d = SETUP;
              ch_d    = ch_q + CH_W'(1);
              sel_d   = ch_q + CH_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      word_q  <= '0;
      sel_q   <= '0;
      d_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign d        = d_q;
  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign done     = done_q;

endmodule

// File: tb/tb_demux_seq.sv
// Bench for demux_seq (DWELL=2): a slot-arithmetic model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_demux_seq;

  localparam int DWELL   = 2;
  localparam int SEQ_LEN = 4 * (DWELL + 1);

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_word;
  logic       in_ready;
  logic       abort;
  logic       d, s1, s0, busy, done;

  int errors = 0;
  int checks = 0;

  demux_seq #(.DWELL(DWELL), .NCH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_word  (in_word),
    .in_ready (in_ready),
    .abort    (abort),
    .d        (d),
    .s1       (s1),
    .s0       (s0),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_k counts cycles since acceptance; slot = channel, pos 0 is the SETUP gap.
  logic       m_busy = 1'b0;
  int         m_k    = 0;
  logic [3:0] m_word = '0;
  logic [1:0] m_sel  = '0;
  logic       m_d    = 1'b0;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic       nb;
    int         nk;
    logic [1:0] ns;
    logic       nd;
    logic [3:0] nw;
    int         slot, pos;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_word <= '0;
      m_sel  <= '0;
      m_d    <= 1'b0;
      m_done <= 1'b0;
    end else begin
      nb = m_busy; nk = m_k; ns = m_sel; nw = m_word; nd = 1'b0;
      m_done <= 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          nb = 1'b1; nk = 1; nw = in_word;
        end
      end else if (abort) begin
        nb = 1'b0; ns = 2'd0;
      end else if (m_k == SEQ_LEN) begin
        nb = 1'b0;
        m_done <= 1'b1;
      end else begin
        nk = m_k + 1;
      end
      if (nb) begin
        slot = (nk - 1) / (DWELL + 1);
        pos  = (nk - 1) % (DWELL + 1);
        ns   = slot[1:0];
        nd   = (pos != 0) && nw[slot];
      end
      m_busy <= nb;
      m_k    <= nk;
      m_sel  <= ns;
      m_word <= nw;
      m_d    <= nd;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [1:0] prev_sel = 2'd0;

  always @(negedge clk) begin
    check("model_d", d, m_d);
    check("model_sel", {s1, s0}, m_sel);
    check("model_busy", busy, m_busy);
    check("model_done", done, m_done);
    check("model_in_ready", in_ready, !m_busy);
    if ({s1, s0} !== prev_sel) check("sel_change_with_d_high", d, 1'b0);
    prev_sel = {s1, s0};
  end

  // ---------------- directed scenarios ----------------
  int lit_sel  [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int lit_d    [13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0};
  int lit_busy [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int lit_done [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int dh;
  int dn;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = 4'd0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_d", d, 0);
    check("reset_sel", {s1, s0}, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 1);

    // Word 1010, accepted on the first edge after reset release.
    rst_n = 1'b1; in_valid = 1'b1; in_word = 4'b1010;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
      check($sformatf("t1_sel_c%0d", n), {s1, s0}, lit_sel[n-1]);
      check($sformatf("t1_d_c%0d", n), d, lit_d[n-1]);
      check($sformatf("t1_busy_c%0d", n), busy, lit_busy[n-1]);
      check($sformatf("t1_done_c%0d", n), done, lit_done[n-1]);
    end

    // Back-to-back: 1111 then 0001 with in_valid held high.
    in_valid = 1'b1; in_word = 4'b1111; dh = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) in_word = 4'b0001;
      if (d) dh++;
    end
    check("t2_done_first", done, 1);
    check("t2_ready_at_done", in_ready, 1);
    check("t2_dhigh_first", dh, 8);
    dh = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        check("t2_second_busy", busy, 1);
        check("t2_second_sel", {s1, s0}, 0);
      end
      if (d) dh++;
    end
    check("t2_done_second", done, 1);
    check("t2_dhigh_second", dh, 2);

    // Abort in cycle 6 of a 1111 sequence.
    in_valid = 1'b1; in_word = 4'b1111;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
    end
    check("t3_pre_abort_d", d, 1);
    check("t3_pre_abort_sel", {s1, s0}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t3_abort_d", d, 0);
    check("t3_abort_sel", {s1, s0}, 0);
    check("t3_abort_busy", busy, 0);
    check("t3_abort_ready", in_ready, 1);
    dn = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t3_no_done", dn, 0);

    // Abort coinciding with accept in IDLE; in_word scrambled while busy.
    in_valid = 1'b1; abort = 1'b1; in_word = 4'b0110; dh = 0;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    check("t4_accept_despite_abort", busy, 1);
    for (int n = 2; n <= 13; n++) begin
      @(negedge clk);
      in_word = 4'($urandom_range(0, 15));
      if (d) dh++;
    end
    check("t4_dhigh_latched", dh, 4);
    check("t4_done", done, 1);

    // Asynchronous reset mid-DRIVE, then accept on the first edge after release.
    in_valid = 1'b1; in_word = 4'b1111;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
    end
    check("t5_pre_reset_d", d, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_d", d, 0);
    check("t5_async_sel", {s1, s0}, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_word = 4'b1000; dh = 0; dn = 0;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_accept_after_reset", busy, 1);
    check("t5_accept_sel", {s1, s0}, 0);
    for (int n = 2; n <= 13; n++) begin
      @(negedge clk);
      if (d) dh++;
      if (done) dn++;
    end
    check("t5_dhigh", dh, 2);
    check("t5_done_once", dn, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
